// File: rtl/pipeline_top_pkg.sv
// Shared types, default baud timing and the 7-segment decoder for the UART GCD node.
package pipeline_top_pkg;

  typedef enum logic [1:0] {
    WAIT_A,
    WAIT_B,
    CALC,
    SEND
  } state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_DONE,
    RX_REARM
  } rx_state_t;

  localparam int CLK_FREQ_DEFAULT = 50_000_000;
  localparam int BAUD_DEFAULT     = 9600;
  localparam int BAUD_DIV         = CLK_FREQ_DEFAULT / BAUD_DEFAULT;
  localparam int HALF_DIV         = BAUD_DIV / 2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order gfedcba, active-low (a lit segment is 0).
  function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/pipeline_top_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte strobe.
// Define GCD_FRAME_CHECK_EN to discard bytes whose stop bit samples low.
module uart_rx
  import pipeline_top_pkg::*;
#(
  parameter int DIV = BAUD_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid
);

  localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);

  rx_state_t   state, next_state;
  logic        sync1, rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
`ifdef GCD_FRAME_CHECK_EN
  logic        stop_bit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      state <= RX_IDLE;
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
      state <= next_state;
    end
  end

  // A start that reads high at its midpoint is treated as a glitch and dropped.
  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:  if (!rx_s) next_state = RX_START;
      RX_START: if (cnt == HALF_LAST) next_state = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == DIV_LAST && bit_idx == 3'd7) next_state = RX_STOP;
      RX_STOP:  if (cnt == DIV_LAST) next_state = RX_DONE;
      RX_DONE:  next_state = RX_REARM;
      RX_REARM: if (rx_s) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    if (state == RX_DONE) begin
`ifdef GCD_FRAME_CHECK_EN
      valid = stop_bit;
`else
      valid = 1'b1;
`endif
    end
  end

  assign data = shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef GCD_FRAME_CHECK_EN
      stop_bit <= 1'b0;
`endif
    end else begin
      case (state)
        RX_START: begin
          cnt     <= (cnt == HALF_LAST) ? '0 : cnt + 16'd1;
          bit_idx <= '0;
        end
        RX_DATA: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
`ifdef GCD_FRAME_CHECK_EN
            stop_bit <= rx_s;
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_top.sv
// UART GCD compute node: two received bytes in, their GCD transmitted back, shown on LEDs/7-seg.
// GCD_FRAME_CHECK_EN (in uart_rx) enables stop-bit framing checks.
module pipeline_top #(
  parameter int CLK_FREQ = pipeline_top_pkg::CLK_FREQ_DEFAULT,
  parameter int BAUD     = pipeline_top_pkg::BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch,
  output logic [7:0] led,
  output logic [6:0] digi_out1,
  output logic [6:0] digi_out2,
  output logic [6:0] digi_out3,
  output logic [6:0] digi_out4,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  import pipeline_top_pkg::*;

  localparam int          DIV      = CLK_FREQ / BAUD;
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  state_t      state, next_state;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  op_a, op_b, res, ca, cb, gcd_out;
  logic [7:0]  tx_shift;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic        tx_line;
  logic        accept_a, accept_b, calc_done, tx_done;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk   (clk),
    .reset (reset),
    .rxd   (uart_rxd),
    .data  (rx_data),
    .valid (rx_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_A;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_A: if (accept_a)  next_state = WAIT_B;
      WAIT_B: if (accept_b)  next_state = CALC;
      CALC:   if (calc_done) next_state = SEND;
      SEND:   if (tx_done)   next_state = WAIT_A;
      default: next_state = WAIT_A;
    endcase
  end

  // Bytes strobed while calculating or sending simply never get an accept.
  always_comb begin
    accept_a  = 1'b0;
    accept_b  = 1'b0;
    calc_done = 1'b0;
    tx_done   = 1'b0;
    case (state)
      WAIT_A: accept_a  = rx_valid;
      WAIT_B: accept_b  = rx_valid;
      CALC:   calc_done = (ca == cb) || (ca == 8'd0) || (cb == 8'd0);
      SEND:   tx_done   = (tx_bit == 4'd9) && (tx_cnt == DIV_LAST);
      default: ;
    endcase
  end

  assign gcd_out = (ca == 8'd0) ? cb : ca;

  // tx_bit: 0 = start, 1..8 = data LSB-first, 9 = stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      ca       <= '0;
      cb       <= '0;
      led      <= '0;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_line  <= 1'b1;
    end else begin
      if (accept_a) begin
        op_a <= rx_data;
        led  <= rx_data;
      end
      if (accept_b) begin
        op_b <= rx_data;
        led  <= rx_data;
        ca   <= op_a;
        cb   <= rx_data;
      end
      if (state == CALC) begin
        if (calc_done) begin
          res      <= gcd_out;
          tx_shift <= gcd_out;
          tx_line  <= 1'b0;
          tx_cnt   <= '0;
          tx_bit   <= '0;
        end else if (ca > cb) begin
          ca <= ca - cb;
        end else begin
          cb <= cb - ca;
        end
      end
      if (state == SEND) begin
        if (tx_cnt == DIV_LAST) begin
          tx_cnt <= '0;
          if (tx_bit != 4'd9) tx_bit <= tx_bit + 4'd1;
          tx_line <= (tx_bit < 4'd8) ? tx_shift[tx_bit[2:0]] : 1'b1;
        end else begin
          tx_cnt <= tx_cnt + 16'd1;
        end
      end
    end
  end

  assign uart_txd = tx_line;

  always_comb begin
    if (switch) begin
      digi_out1 = seg7_hex(res[3:0]);
      digi_out2 = seg7_hex(res[7:4]);
      digi_out3 = SEG_BLANK;
      digi_out4 = SEG_BLANK;
    end else begin
      digi_out1 = seg7_hex(op_a[3:0]);
      digi_out2 = seg7_hex(op_a[7:4]);
      digi_out3 = seg7_hex(op_b[3:0]);
      digi_out4 = seg7_hex(op_b[7:4]);
    end
  end

endmodule

// File: tb/tb_pipeline_top.sv
// Directed bench for pipeline_top: UART operand pairs in, GCD frames out, glitch/framing/reset cases.
// Build with or without GCD_FRAME_CHECK_EN; the framing case adapts to the macro.
module tb_pipeline_top;
  import pipeline_top_pkg::*;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       switch = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] led;
  logic [6:0] digi_out1, digi_out2, digi_out3, digi_out4;
  logic       uart_txd;

  int check_count = 0;
  int pass_count  = 0;
  int cyc         = 0;
  int strobes     = 0;
  int stop_cyc    = 0;

  pipeline_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .switch    (switch),
    .led       (led),
    .digi_out1 (digi_out1),
    .digi_out2 (digi_out2),
    .digi_out3 (digi_out3),
    .digi_out4 (digi_out4),
    .uart_rxd  (uart_rxd),
    .uart_txd  (uart_txd)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.rx_valid) strobes <= strobes + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  // Drives one 8N1 frame on uart_rxd plus one idle bit; called at a negedge.
  task automatic applyStimulus(input logic [7:0] value, input logic stop_lvl);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = value[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = stop_lvl;
    stop_cyc = cyc;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic wait_tx_fall(output int fall_cyc);
    int n = 0;
    while (uart_txd !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_start_seen", 32'(uart_txd), 32'd0);
    fall_cyc = cyc;
  endtask

  task automatic capture_frame(output logic [7:0] value, output logic stop_v, output int fall_cyc);
    wait_tx_fall(fall_cyc);
    repeat (DIV / 2) @(negedge clk);
    checkOutput("tx_start_bit", 32'(uart_txd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      value[i] = uart_txd;
    end
    repeat (DIV) @(negedge clk);
    stop_v = uart_txd;
  endtask

  task automatic finish_pair(input logic [7:0] b, output logic [7:0] value, output logic stop_v,
                             output int latency);
    int fall_cyc;
    fork
      applyStimulus(b, 1'b1);
      capture_frame(value, stop_v, fall_cyc);
    join
    latency = fall_cyc - stop_cyc;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic run_gcd(input logic [7:0] a, input logic [7:0] b, output logic [7:0] value,
                         output logic stop_v, output int latency);
    applyStimulus(a, 1'b1);
    finish_pair(b, value, stop_v, latency);
  endtask

  task automatic check_digits(input string tag, input logic [6:0] d1, input logic [6:0] d2,
                              input logic [6:0] d3, input logic [6:0] d4);
    checkOutput({tag, "_d1"}, 32'(digi_out1), 32'(d1));
    checkOutput({tag, "_d2"}, 32'(digi_out2), 32'(d2));
    checkOutput({tag, "_d3"}, 32'(digi_out3), 32'(d3));
    checkOutput({tag, "_d4"}, 32'(digi_out4), 32'(d4));
  endtask

  initial begin
    logic [7:0] value;
    logic       stop_v;
    int         latency;
    int         fall_cyc;
    int         strobes_before;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_txd", 32'(uart_txd), 32'd1);
    checkOutput("rst_led", 32'(led), 32'h00);
    checkOutput("rst_state", 32'(dut.state), 32'(WAIT_A));
    check_digits("rst", 7'h40, 7'h40, 7'h40, 7'h40);

    $display("[TB] gcd(0x3C,0x24)");
    run_gcd(8'h3C, 8'h24, value, stop_v, latency);
    checkOutput("g1_led", 32'(led), 32'h24);
    checkOutput("g1_tx_data", 32'(value), 32'h0C);
    checkOutput("g1_tx_stop", 32'(stop_v), 32'd1);
    checkOutput("g1_latency_ok", 32'(latency < 300), 32'd1);
    checkOutput("g1_state", 32'(dut.state), 32'(WAIT_A));
    check_digits("g1_ops", 7'h46, 7'h30, 7'h19, 7'h24);
    switch = 1'b1;
    #1;
    check_digits("g1_res", 7'h46, 7'h40, 7'h7F, 7'h7F);
    @(negedge clk);
    switch = 1'b0;

    $display("[TB] zero operands");
    run_gcd(8'h00, 8'h15, value, stop_v, latency);
    checkOutput("g2_tx_data", 32'(value), 32'h15);
    checkOutput("g2_tx_stop", 32'(stop_v), 32'd1);
    switch = 1'b1;
    #1;
    checkOutput("g2_res_d1", 32'(digi_out1), 32'h12);
    checkOutput("g2_res_d2", 32'(digi_out2), 32'h79);
    @(negedge clk);
    switch = 1'b0;
    run_gcd(8'h00, 8'h00, value, stop_v, latency);
    checkOutput("g3_tx_data", 32'(value), 32'h00);
    checkOutput("g3_tx_stop", 32'(stop_v), 32'd1);
    checkOutput("g3_led", 32'(led), 32'h00);

    $display("[TB] rx glitch");
    strobes_before = strobes;
    uart_rxd = 1'b0;
    repeat (6) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    checkOutput("glitch_strobes", 32'(strobes), 32'(strobes_before));
    checkOutput("glitch_state", 32'(dut.state), 32'(WAIT_A));
    checkOutput("glitch_led", 32'(led), 32'h00);

    $display("[TB] stop bit low");
    strobes_before = strobes;
    applyStimulus(8'h77, 1'b0);
`ifdef GCD_FRAME_CHECK_EN
    checkOutput("frame_led", 32'(led), 32'h00);
    checkOutput("frame_state", 32'(dut.state), 32'(WAIT_A));
    checkOutput("frame_strobes", 32'(strobes), 32'(strobes_before));
    applyStimulus(8'h77, 1'b1);
`else
    checkOutput("frame_led", 32'(led), 32'h77);
    checkOutput("frame_state", 32'(dut.state), 32'(WAIT_B));
    checkOutput("frame_strobes", 32'(strobes), 32'(strobes_before + 1));
`endif
    finish_pair(8'h0E, value, stop_v, latency);
    checkOutput("g4_tx_data", 32'(value), 32'h07);
    checkOutput("g4_tx_stop", 32'(stop_v), 32'd1);

    $display("[TB] reset during tx");
    applyStimulus(8'h91, 1'b1);
    fork
      applyStimulus(8'h13, 1'b1);
      wait_tx_fall(fall_cyc);
    join
    while (cyc < fall_cyc + 40) @(negedge clk);
    checkOutput("midtx_low", 32'(uart_txd), 32'd0);
    checkOutput("midtx_led", 32'(led), 32'h13);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_txd", 32'(uart_txd), 32'd1);
    checkOutput("midrst_state", 32'(dut.state), 32'(WAIT_A));
    checkOutput("midrst_led", 32'(led), 32'h00);
    check_digits("midrst_ops", 7'h40, 7'h40, 7'h40, 7'h40);
    switch = 1'b1;
    #1;
    check_digits("midrst_res", 7'h40, 7'h40, 7'h7F, 7'h7F);
    @(negedge clk);
    switch = 1'b0;
    reset = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    checkOutput("postrst_txd", 32'(uart_txd), 32'd1);
    checkOutput("postrst_state", 32'(dut.state), 32'(WAIT_A));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
